fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives the word address into the combinational instruction memory, and captures the returned word into the IF/ID pipeline register for decode. Handles sequential fetch, branch/jump redirect from later stages, hazard stalls and pipeline flushes. Also keeps a retired-fetch counter for bring-up and performance checks.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- Clk  in  1  core clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Stall  in  1  hazard stall from decode; holds PC and IF/ID.
- Flush  in  1  squash the IF/ID contents (bubble insert).
- Redirect  in  1  taken branch/jump/jr resolved downstream.
- RedirectPC  in  32  target address for Redirect.
- IMemAddress  out  32  byte address to instruction memory (word-aligned).
- IMemInstruction  in  32  instruction word returned combinationally for IMemAddress.
- PC  out  32  current PC (same value as IMemAddress).
- IF_ID_Instruction  out  32  registered instruction for decode.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  1 = IF/ID holds a real instruction; 0 = bubble.
- FetchCount  out  32  number of instructions accepted into IF/ID.

## Operation
- Reset (Rst=0, asynchronous): PC=RESET_PC, IF_ID_Instruction=0 (nop), IF_ID_PCPlus4=0, IF_ID_Valid=0, FetchCount=0. Held while Rst=0 regardless of other inputs.
- IMemAddress = {PC[31:2], 2'b00}; PC[1:0] always 0.
- PCPlus4 = PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Next PC priority: Redirect -> {RedirectPC[31:2],2'b00}; else Stall -> hold PC; else PCPlus4.
- IF/ID update, squash = Flush | Redirect: squash -> Instruction=0, PCPlus4=0, Valid=0 (wins over Stall); else Stall -> hold all three; else load IMemInstruction, PCPlus4, Valid=1.
- FetchCount increments by 1 only in the load case; saturates at 0xFFFF_FFFF (no wrap).
- Redirect with Stall: PC takes target, IF/ID bubbled; stall does not block redirect.
- Flush without Redirect: PC still obeys Stall/sequential rule; only IF/ID is bubbled.
- No internal state machine beyond PC, IF/ID and counter; no memory write path.

## Timing
- Fetch latency: instruction at address A appears on IF_ID_Instruction one rising edge after PC=A with no stall/squash.
- IMemAddress/PC change only on rising edge or asynchronous reset; no combinational path from any input to IMemAddress.
- Redirect asserted before edge N: after N, PC=target and IF_ID_Valid=0; target instruction valid in IF/ID after edge N+1 (one-bubble penalty).
- Stall for k cycles: PC and IF/ID unchanged for k edges; sequential fetch resumes on first edge with Stall=0.
- Reset asserted mid-operation: all outputs take reset values immediately (no edge needed); first fetch of RESET_PC completes on first edge after Rst returns high.
- Inputs Stall, Flush, Redirect, RedirectPC sampled only at rising edge.

## Test plan
- Reset then 4 free-running edges, memory word[i]=i*4 -> IF_ID_Instruction 0,4,8,12; IF_ID_PCPlus4 4,8,12,16; Valid=1; FetchCount=4; PC=0x10.
- Stall high for 3 edges at PC=0x08 -> PC stays 0x08, IF/ID holds word 4/PCPlus4 8, FetchCount unchanged; release -> word 8 loaded next edge.
- Redirect with RedirectPC=0x0000_0043 at PC=0x0C -> PC=0x40, Valid=0; next edge IF_ID_Instruction=0x40, PCPlus4=0x44, Valid=1.
- Redirect and Stall together, RedirectPC=0x20 -> PC=0x20 and bubble on same edge; Flush alone -> Valid=0, PC advances by 4.
- RESET_PC=0xFFFF_FFFC, release reset, 2 edges -> PC 0x0000_0000 then 0x0000_0004; IF_ID_PCPlus4=0x0000_0000 after first edge.
- Assert Rst mid-run between edges with FetchCount=7 -> PC=RESET_PC, Valid=0, FetchCount=0 immediately, stable until Rst deasserts.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID register for decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] IMemAddress,
    input  logic [31:0] IMemInstruction,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PCPlus4,
    output logic        IF_ID_Valid,
    output logic [31:0] FetchCount
);

    logic [31:0] r_pc;
    logic [31:0] r_if_id_instruction;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_squash;
    logic        w_load;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_squash   = Flush | Redirect;
    assign w_load     = !w_squash && !Stall;

    // A redirect must never be blocked by a decode stall, so it is tested first.
    always_comb begin
        // NOTE: default assignment first so every path drives w_next_pc and no latch is inferred.
        w_next_pc = w_pc_plus4;
        if (Redirect) begin
            w_next_pc = {RedirectPC[31:2], 2'b00};
        end else if (Stall) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            // NOTE: non-blocking assignments for all registered state so every update sees pre-edge values.
            r_pc                <= {RESET_PC[31:2], 2'b00};
            r_if_id_instruction <= 32'd0;
            r_if_id_pc_plus4    <= 32'd0;
            r_if_id_valid       <= 1'b0;
            r_fetch_count       <= 32'd0;
        end else begin
            r_pc <= w_next_pc;
            if (w_squash) begin
                r_if_id_instruction <= 32'd0;
                r_if_id_pc_plus4    <= 32'd0;
                r_if_id_valid       <= 1'b0;
            end else if (w_load) begin
                r_if_id_instruction <= IMemInstruction;
                r_if_id_pc_plus4    <= w_pc_plus4;
                r_if_id_valid       <= 1'b1;
            end
            // Counter saturates rather than wrapping so long runs never read as short ones.
            if (w_load && (r_fetch_count != 32'hFFFF_FFFF)) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign IMemAddress       = r_pc;
    assign PC                = r_pc;
    assign IF_ID_Instruction = r_if_id_instruction;
    assign IF_ID_PCPlus4     = r_if_id_pc_plus4;
    assign IF_ID_Valid       = r_if_id_valid;
    assign FetchCount        = r_fetch_count;

endmodule
